paralelo_serial: RTL and testbench
==================================

PARALELO_SERIAL -- requirements
Module: paralelo_serial

Interface
REQ-001 Parameter SYNC_COUNT, default 4: number of comma bytes sent after reset before data is accepted (legal range 1..15).
REQ-002 Parameter COMMA, default 8'hBC: idle/alignment byte.
REQ-003 clk_32f  input  1  bit clock; one serial bit per rising edge; the only clock in the block.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk_32f.
REQ-005 data_in  input  8  parallel byte offered for transmission.
REQ-006 valid_in  input  1  data_in holds a valid byte.
REQ-007 data_out  output  1  registered serial bit stream, MSB first.
REQ-008 ready  output  1  high for exactly one cycle per byte slot, in DATA state only; a byte is accepted on the edge where ready && valid_in.
REQ-009 active  output  1  registered; high once the alignment preamble is complete.

Function
REQ-010 The block SHALL have two states: SYNC (preamble) and DATA.
REQ-011 It SHALL keep a 3-bit bit_cnt giving the index of the bit currently on data_out (0 = MSB), an 8-bit shift register, and a 4-bit sync counter.
REQ-012 A load edge is any rising edge with reset low and bit_cnt == 7.
- On a load edge, the next byte is taken into the shift register, data_out <= byte[7], and bit_cnt <= 0.
- On every other edge, data_out <= next lower bit and bit_cnt increments.
- Period: exactly one byte per 8 clocks, no gaps.
REQ-013 In SYNC, every load edge SHALL load COMMA and increment the sync counter.
- On the load edge that loads the SYNC_COUNT-th comma, state <= DATA and active <= 1.
REQ-014 In DATA, on a load edge:
- valid_in = 1: load data_in.
- valid_in = 0: load COMMA (idle insertion).
- active stays 1.
REQ-015 ready SHALL equal (state == DATA) && (bit_cnt == 7), decoded from registered state; it is 0 throughout SYNC.
REQ-016 data_in and valid_in SHALL be sampled only on load edges and ignored on all other edges.
REQ-017 A data byte equal to COMMA SHALL be transmitted unchanged and SHALL NOT be flagged.
REQ-018 bit_cnt SHALL wrap 7 -> 0 only via a load edge; the sync counter SHALL saturate and not wrap while in DATA.
REQ-019 Latency: a byte accepted on load edge E appears on data_out as bit7 after E through bit0 after E+7.

Reset
REQ-020 While reset is high at a rising edge, the block SHALL set:
- data_out = 0, active = 0, ready = 0
- state = SYNC, sync counter = 0
- bit_cnt = 7, shift register = 0
REQ-021 Reset mid-byte SHALL discard the partial byte, with no completion of the remaining bits.
REQ-022 The first edge with reset low SHALL be a load edge that starts the preamble.
REQ-023 Reset SHALL have priority over all other inputs.

Verification (edges numbered from 0 = first rising edge with reset low, SYNC_COUNT = 4)
REQ-024 Reset, valid_in = 0 throughout:
- data_out repeats 1,0,1,1,1,1,0,0 from edge 0.
- active rises after edge 24.
- ready is high only during cycles after edges 31, 39, 47, ...
REQ-025 valid_in = 1 with data_in = 8'hFF during the ready cycle after edge 31:
- data_out = 1 after edges 32..39.
- No ready pulse before that cycle.
REQ-026 Back-to-back data_in = 8'hEE, then 8'hBC, with valid_in held high:
- Bits after edges 32..47 are 1110111010111100.
- ready is high during the cycles after edges 31 and 39.
REQ-027 valid_in dropped during the ready cycle after edge 39:
- Comma 10111100 is sent after edges 40..47.
- The next valid byte goes out from edge 48.
REQ-028 valid_in pulsed high only in a non-ready cycle (e.g. after edge 34): the byte is not sent, and a comma follows at edge 40.
REQ-029 reset asserted at edge 35:
- data_out, active and ready are 0 while reset is held.
- After release, the full 4-comma preamble repeats before active rises.

Source files
------------

// File: rtl/paralelo_serial.sv
// Purpose: byte-to-bit serializer, MSB first, with a comma preamble after reset and comma idle fill.
// Latency: a byte accepted on load edge E drives data_out with bit7 after E through bit0 after E+7.
// Backpressure: ready pulses once per 8-clock byte slot; a byte missing from that slot becomes a comma.
//
// Ports:
//   clk_32f   in   bit clock, one serial bit per rising edge
//   reset     in   synchronous, active-high
//   data_in   in   [7:0] parallel byte offered for transmission
//   valid_in  in   data_in holds a valid byte (sampled only on load edges)
//   data_out  out  registered serial bit, MSB first
//   ready     out  high for the one cycle per byte slot in which a byte is accepted
//   active    out  registered, high once the comma preamble has been sent
module paralelo_serial #(
  parameter int         SYNC_COUNT = 4,
  parameter logic [7:0] COMMA      = 8'hBC
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       data_out,
  output logic       ready,
  output logic       active
);

  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;

  // Sync counter value on the load edge that sends the last preamble comma.
  localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);

  logic [0:0] state;
  logic [2:0] bit_cnt;   // index of the bit currently on data_out, 0 = MSB
  logic [7:0] shreg;
  logic [3:0] sync_cnt;
  logic [7:0] next_byte;
  logic       load_edge;

  // bit_cnt resets to 7 so the first edge after reset is already a load edge.
  assign load_edge = (bit_cnt == 3'd7);

  // Only DATA state looks at the input; everything else sends a comma.
  always_comb begin
    next_byte = COMMA;
    if (state == ST_DATA && valid_in) begin
      next_byte = data_in;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state    <= ST_SYNC;
      bit_cnt  <= 3'd7;
      shreg    <= 8'h00;
      sync_cnt <= 4'd0;
      data_out <= 1'b0;
      active   <= 1'b0;
    end else if (load_edge) begin
      shreg    <= next_byte;
      data_out <= next_byte[7];
      bit_cnt  <= 3'd0;
      // Counter only advances during the preamble, so it stops at SYNC_COUNT.
      if (state == ST_SYNC) begin
        sync_cnt <= sync_cnt + 4'd1;
        if (sync_cnt == SYNC_LAST) begin
          state  <= ST_DATA;
          active <= 1'b1;
        end
      end
    end else begin
      // Rotate rather than shift so the register always holds the whole byte;
      // bit 6 is the next bit to go out.
      data_out <= shreg[6];
      shreg    <= {shreg[6:0], shreg[7]};
      bit_cnt  <= bit_cnt + 3'd1;
    end
  end

  assign ready = (state == ST_DATA) && load_edge;

endmodule

// File: tb/tb_paralelo_serial.sv
module tb_paralelo_serial;

  localparam int         SC    = 4;
  localparam logic [7:0] COMMA = 8'hBC;

  logic       clk_32f  = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] data_in  = 8'h00;
  logic       valid_in = 1'b0;
  logic       data_out;
  logic       ready;
  logic       active;

  paralelo_serial #(.SYNC_COUNT(SC), .COMMA(COMMA)) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .data_out (data_out),
    .ready    (ready),
    .active   (active)
  );

  always #5 clk_32f = ~clk_32f;

  int tests = 0;
  int fails = 0;

  // Model state: n is the number of the last edge with reset low (-1 = in reset).
  int         n        = -1;
  logic       exp_dout = 1'b0;
  logic       exp_act  = 1'b0;
  logic       exp_rdy  = 1'b0;
  logic [7:0] cur_byte = COMMA;

  // DUT outputs captured in the cycle after edge n, for literal checks.
  logic dut_bits [128];
  logic dut_act  [128];
  logic dut_rdy  [128];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (edge %0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  // Byte-slot model: edge n carries bit (n mod 8) of byte slot n/8. Slots before
  // SC are commas; later slots carry data_in if valid_in was high at the slot's
  // first edge, otherwise a comma.
  always @(posedge clk_32f) begin
    if (reset) begin
      n        = -1;
      exp_dout = 1'b0;
      exp_act  = 1'b0;
      exp_rdy  = 1'b0;
    end else begin
      n = n + 1;
      if (n % 8 == 0) begin
        cur_byte = ((n / 8) >= SC && valid_in) ? data_in : COMMA;
      end
      exp_dout = cur_byte[3'(7 - (n % 8))];
      exp_act  = (n >= 8 * (SC - 1));
      exp_rdy  = (n % 8 == 7) && (n >= 8 * SC - 1);
    end
  end

  // Single compare process, sampling on the falling edge.
  always @(negedge clk_32f) begin
    chk("data_out", 32'(data_out), 32'(exp_dout));
    chk("active",   32'(active),   32'(exp_act));
    chk("ready",    32'(ready),    32'(exp_rdy));
    if (n >= 0 && n < 128) begin
      dut_bits[n] = data_out;
      dut_act[n]  = active;
      dut_rdy[n]  = ready;
    end
  end

  task automatic clear_log();
    for (int i = 0; i < 128; i++) begin
      dut_bits[i] = 1'b0;
      dut_act[i]  = 1'b0;
      dut_rdy[i]  = 1'b0;
    end
  endtask

  task automatic get_bits(input int s, input int len, output logic [31:0] v);
    v = '0;
    for (int i = 0; i < len; i++) v = {v[30:0], dut_bits[s + i]};
  endtask

  // Advance to 2ns after edge k; bounded.
  task automatic run_to(input int k);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk_32f);
      #2;
      if (n == k) return;
    end
    tests++;
    fails++;
    $display("FAIL run_to: edge %0d never reached, model at %0d", k, n);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    repeat (3) begin
      @(posedge clk_32f);
      #2;
    end
    clear_log();
    reset = 1'b0;
  endtask

  logic [31:0] v;
  logic        any_rdy;

  initial begin
    // A: idle, valid_in low throughout
    do_reset();
    run_to(55);
    get_bits(0, 32, v);  chk("A_preamble",  v, 32'hBCBCBCBC);
    get_bits(32, 24, v); chk("A_idle",      v, 32'h00BCBCBC);
    chk("A_act23", 32'(dut_act[23]), 32'd0);
    chk("A_act24", 32'(dut_act[24]), 32'd1);
    chk("A_rdy23", 32'(dut_rdy[23]), 32'd0);
    chk("A_rdy30", 32'(dut_rdy[30]), 32'd0);
    chk("A_rdy31", 32'(dut_rdy[31]), 32'd1);
    chk("A_rdy39", 32'(dut_rdy[39]), 32'd1);

    // B: one 0xFF byte offered in the first ready cycle
    do_reset();
    run_to(31);
    valid_in = 1'b1; data_in = 8'hFF;
    run_to(32);
    valid_in = 1'b0; data_in = 8'h00;
    run_to(47);
    get_bits(32, 8, v); chk("B_ff",    v, 32'h000000FF);
    get_bits(40, 8, v); chk("B_comma", v, 32'h000000BC);
    any_rdy = 1'b0;
    for (int i = 0; i < 31; i++) any_rdy = any_rdy | dut_rdy[i];
    chk("B_no_early_rdy", 32'(any_rdy), 32'd0);

    // C: EE then BC back to back, valid held high even through the preamble
    do_reset();
    valid_in = 1'b1; data_in = 8'hEE;
    run_to(32);
    data_in = 8'hBC;
    run_to(47);
    valid_in = 1'b0;
    get_bits(0, 32, v);  chk("C_preamble", v, 32'hBCBCBCBC);
    get_bits(32, 16, v); chk("C_ee_bc",    v, 32'h0000EEBC);
    chk("C_rdy31", 32'(dut_rdy[31]), 32'd1);
    chk("C_rdy35", 32'(dut_rdy[35]), 32'd0);
    chk("C_rdy39", 32'(dut_rdy[39]), 32'd1);

    // D: valid dropped in the second ready cycle, resumed in the third
    do_reset();
    valid_in = 1'b1; data_in = 8'h5A;
    run_to(39);
    valid_in = 1'b0;
    run_to(47);
    valid_in = 1'b1; data_in = 8'h3C;
    run_to(48);
    valid_in = 1'b0;
    run_to(55);
    get_bits(32, 24, v); chk("D_5a_bc_3c", v, 32'h005ABC3C);

    // E: valid pulsed outside a ready cycle is ignored
    do_reset();
    run_to(34);
    valid_in = 1'b1; data_in = 8'h00;
    run_to(35);
    valid_in = 1'b0;
    run_to(47);
    get_bits(32, 16, v); chk("E_ignored", v, 32'h0000BCBC);

    // F: reset mid-byte, then the full preamble again
    do_reset();
    valid_in = 1'b1; data_in = 8'h0F;
    run_to(34);
    reset = 1'b1;
    valid_in = 1'b0;
    @(posedge clk_32f);
    #2;
    chk("F_rst_dout",   32'(data_out), 32'd0);
    chk("F_rst_active", 32'(active),   32'd0);
    chk("F_rst_ready",  32'(ready),    32'd0);
    repeat (2) begin
      @(posedge clk_32f);
      #2;
    end
    clear_log();
    reset = 1'b0;
    run_to(39);
    get_bits(0, 32, v); chk("F_preamble", v, 32'hBCBCBCBC);
    chk("F_act23", 32'(dut_act[23]), 32'd0);
    chk("F_act24", 32'(dut_act[24]), 32'd1);
    chk("F_rdy31", 32'(dut_rdy[31]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
